// File: rtl/mult_pkg.sv
// Package shared by the dot-product accumulator stage.
//   dot_state_t : FSM state encoding (IDLE, ACC, DONE)
//   PROD_W      : width of the unsigned product stream from the 8x8 multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } dot_state_t;

  localparam int PROD_W = 16;

endpackage : mult_pkg

// File: rtl/acc_adder.sv
// Accumulator adder: a + b with carry out of the top bit.
// Configuration macro: MULT_DOT_ACCUM_SAT_EN
//   defined   -> sum clamps to all ones whenever the add carries out
//   undefined -> sum wraps modulo 2^ACC_W
// Ports:
//   a     in  ACC_W  running accumulator value
//   b     in  ACC_W  zero-extended product
//   sum   out ACC_W  next accumulator value (saturated or wrapped)
//   carry out 1      carry out of bit ACC_W-1 (overflow indication)
module acc_adder #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W-1:0] w_raw;

  // One extra bit on the left captures the carry without a separate compare.
  assign {carry, w_raw} = {1'b0, a} + {1'b0, b};

`ifdef MULT_DOT_ACCUM_SAT_EN
  // Once clamped, any further non-zero add carries again, so the value sticks.
  assign sum = carry ? {ACC_W{1'b1}} : w_raw;
`else
  assign sum = w_raw;
`endif

endmodule : acc_adder

// File: rtl/mult_dot_accum.sv
// Dot-product accumulator placed after the 8x8 CSA-tree multiplier.
// Sums len unsigned 16-bit products taken over a valid/ready handshake and
// presents the sum on a valid/ready output held until consumed.
// Configuration macro: MULT_DOT_ACCUM_SAT_EN (saturating add, see acc_adder).
// Ports:
//   clk        in  1      rising-edge clock
//   reset_n    in  1      asynchronous active-low reset
//   start      in  1      begin a new dot product (IDLE only)
//   len        in  LEN_W  number of products; captured on accepted start
//   prod       in  16     unsigned product
//   prod_valid in  1      prod valid
//   prod_ready out 1      block accepts prod (ACC state)
//   acc_out    out ACC_W  dot-product result
//   acc_valid  out 1      result valid, held until acc_ready
//   acc_ready  in  1      consumer takes acc_out
//   ovf        out 1      sticky overflow for the current result
//   busy       out 1      high in ACC or DONE
module mult_dot_accum
  import mult_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  dot_state_t       r_state;
  dot_state_t       w_next_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_start_ok;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_accept   = (r_state == ACC) && prod_valid;
  // r_len is never zero in ACC: a zero-length start goes straight to DONE.
  assign w_last     = w_accept && (r_count == (r_len - LEN_W'(1)));

  acc_adder #(.ACC_W(ACC_W)) u_adder (
    .a     (r_acc),
    .b     (ACC_W'(prod)),
    .sum   (w_sum),
    .carry (w_carry)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    w_next_state = r_state;
    prod_ready   = 1'b0;
    acc_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = (len == '0) ? DONE : ACC;
      end
      ACC: begin
        prod_ready = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        acc_valid = 1'b1;
        if (acc_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start_ok) begin
        r_len   <= len;
        r_count <= '0;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        r_acc   <= w_sum;
        r_count <= r_count + LEN_W'(1);
        r_ovf   <= r_ovf | w_carry;
      end
    end
  end

  assign acc_out = r_acc;
  assign ovf     = r_ovf;

endmodule : mult_dot_accum

// File: tb/tb_mult_dot_accum.sv
// Bench for mult_dot_accum: a 24-bit instance for the functional vectors and
// a 16-bit instance for the overflow vector. Stimulus pushes expected results
// into per-instance queues; monitors pop and compare on each output handshake.
module tb_mult_dot_accum;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        start, prod_valid, acc_ready;
  logic [7:0]  len;
  logic [15:0] prod;
  logic        prod_ready, acc_valid, ovf, busy;
  logic [23:0] acc_out;

  logic        s_start, s_prod_valid, s_acc_ready;
  logic [7:0]  s_len;
  logic [15:0] s_prod;
  logic        s_prod_ready, s_acc_valid, s_ovf, s_busy;
  logic [15:0] s_acc_out;

  exp_t q24[$];
  exp_t q16[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mult_dot_accum #(.ACC_W(24), .LEN_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .ovf(ovf), .busy(busy)
  );

  mult_dot_accum #(.ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .len(s_len),
    .prod(s_prod), .prod_valid(s_prod_valid), .prod_ready(s_prod_ready),
    .acc_out(s_acc_out), .acc_valid(s_acc_valid), .acc_ready(s_acc_ready),
    .ovf(s_ovf), .busy(s_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (reset_n && acc_valid && acc_ready) begin
      if (q24.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result24: got acc %0d with no expected entry", acc_out);
      end else begin
        exp_t e;
        e = q24.pop_front();
        check("result24_acc", 32'(acc_out), e.acc);
        check("result24_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && s_acc_valid && s_acc_ready) begin
      if (q16.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result16: got acc %0d with no expected entry", s_acc_out);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("result16_acc", 32'(s_acc_out), e.acc);
        check("result16_ovf", 32'(s_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bub_prod [5];
    logic        bub_vld  [5];
    bub_prod = '{16'd100, 16'd999, 16'd200, 16'd999, 16'd300};
    bub_vld  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0;
    start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; acc_ready = 1'b1;
    s_start = 1'b0; s_len = '0; s_prod = '0; s_prod_valid = 1'b0; s_acc_ready = 1'b1;
    #12;
    check("reset_acc_out",    32'(acc_out),    0);
    check("reset_acc_valid",  32'(acc_valid),  0);
    check("reset_prod_ready", 32'(prod_ready), 0);
    check("reset_ovf",        32'(ovf),        0);
    check("reset_busy",       32'(busy),       0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Vector 1: len 3, back-to-back beats.
    q24.push_back('{acc: 600, ovf: 1'b0});
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    check("v1_prod_ready", 32'(prod_ready), 1);
    prod_valid = 1'b1;
    prod = 16'd100; tick();
    prod = 16'd200; tick();
    prod = 16'd300; tick();
    prod_valid = 1'b0;
    check("v1_latency_valid", 32'(acc_valid), 1);
    tick();
    check("v1_single_cycle_valid", 32'(acc_valid), 0);

    // Vector 2: same stream with bubbles.
    q24.push_back('{acc: 600, ovf: 1'b0});
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prod = bub_prod[i]; prod_valid = bub_vld[i]; tick();
      if (i == 1) check("v2_hold_in_bubble", 32'(acc_out), 100);
    end
    prod_valid = 1'b0;
    check("v2_valid_after_last", 32'(acc_valid), 1);
    tick();

    // Vector 3: zero length, a valid product offered but never taken.
    q24.push_back('{acc: 0, ovf: 1'b0});
    prod = 16'd55; prod_valid = 1'b1;
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    check("v3_prod_ready_done", 32'(prod_ready), 0);
    check("v3_valid", 32'(acc_valid), 1);
    tick();
    check("v3_prod_ready_idle", 32'(prod_ready), 0);
    prod_valid = 1'b0;

    // Vector 4: back-pressure plus ignored starts in ACC and DONE.
    acc_ready = 1'b0;
    q24.push_back('{acc: 11, ovf: 1'b0});
    start = 1'b1; len = 8'd2; tick();
    prod_valid = 1'b1; prod = 16'd5; len = 8'd9; tick();
    start = 1'b0; prod = 16'd6; tick();
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      tick();
      check("v4_stall_valid", 32'(acc_valid), 1);
      check("v4_stall_acc", 32'(acc_out), 11);
    end
    acc_ready = 1'b1; start = 1'b1; len = 8'd1; tick();
    start = 1'b0; tick();
    check("v4_start_on_handoff_ignored", 32'(busy), 0);
    check("v4_valid_dropped", 32'(acc_valid), 0);

    // Vector 5: 16-bit accumulator overflow.
`ifdef MULT_DOT_ACCUM_SAT_EN
    q16.push_back('{acc: 65535, ovf: 1'b1});
`else
    q16.push_back('{acc: 64514, ovf: 1'b1});
`endif
    s_start = 1'b1; s_len = 8'd2; tick(); s_start = 1'b0;
    s_prod_valid = 1'b1; s_prod = 16'd65025; tick(); tick();
    s_prod_valid = 1'b0;
    check("v5_valid", 32'(s_acc_valid), 1);
    tick();

    // Vector 6: reset mid-vector, then a fresh len-1 vector.
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 16'd9; tick();
    prod_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    check("v6_rst_acc_out",    32'(acc_out),    0);
    check("v6_rst_acc_valid",  32'(acc_valid),  0);
    check("v6_rst_prod_ready", 32'(prod_ready), 0);
    check("v6_rst_ovf",        32'(ovf),        0);
    check("v6_rst_busy",       32'(busy),       0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    q24.push_back('{acc: 7, ovf: 1'b0});
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    prod_valid = 1'b1; prod = 16'd7; tick();
    prod_valid = 1'b0;
    check("v6_valid", 32'(acc_valid), 1);

    for (int i = 0; i < 20 && (q24.size() != 0 || q16.size() != 0); i++) tick();
    tick();
    check("drain24", 32'(q24.size()), 0);
    check("drain16", 32'(q16.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mult_dot_accum
